// File: rtl/gb_pkg.sv
// Shared Game Boy bus definitions: DMA state encoding, fixed addresses and echo-RAM source mapping.
package gb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        READ,
        WRITE
    } dma_state_t;

    localparam logic [15:0] ADDR_DMA      = 16'hFF46;
    localparam logic [15:0] ADDR_OAM_BASE = 16'hFE00;
    localparam logic [15:0] ADDR_HRAM_LO  = 16'hFF80;
    localparam logic [15:0] ADDR_HRAM_HI  = 16'hFFFE;
    localparam int          OAM_LEN       = 160;

    // Pages E0..FF alias work RAM at C0..DF.
    function automatic logic [7:0] map_src(input logic [7:0] s);
        return (s >= 8'hE0) ? (s - 8'h20) : s;
    endfunction

endpackage

// File: rtl/oam_dma_controller.sv
// OAM DMA engine and CPU/DMA bus arbiter between the CPU and memory_controller.
// One byte per READ/WRITE pair; HRAM-window CPU cycles pre-empt the DMA, other CPU traffic is blocked while busy.
module oam_dma_controller
    import gb_pkg::*;
#(
    parameter logic [15:0] REG_ADDR = ADDR_DMA,
    parameter logic [15:0] OAM_BASE = ADDR_OAM_BASE,
    parameter int          LENGTH   = OAM_LEN,
    parameter logic [15:0] HRAM_LO  = ADDR_HRAM_LO,
    parameter logic [15:0] HRAM_HI  = ADDR_HRAM_HI
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [15:0] A_cpu,
    input  logic [7:0]  Do_cpu,
    output logic [7:0]  Di_cpu,
    input  logic        rd_cpu_n,
    input  logic        wr_cpu_n,
    output logic [15:0] A,
    output logic [7:0]  Do,
    input  logic [7:0]  Di,
    output logic        rd_n,
    output logic        wr_n,
    output logic        busy
);

    localparam logic [7:0] LAST_IDX = 8'(LENGTH - 1);

    dma_state_t state_q, state_d;
    logic [7:0] src_q, src_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] data_q, data_d;
    logic       wr_prev_q;

    logic reg_hit, hram_hit, cpu_owns, reg_wr_start;

    assign reg_hit      = (A_cpu == REG_ADDR);
    assign hram_hit     = (A_cpu >= HRAM_LO) && (A_cpu <= HRAM_HI);
    assign cpu_owns     = (!rd_cpu_n || !wr_cpu_n) && hram_hit;
    // Edge-detect the write strobe so a multi-cycle CPU write starts only one transfer.
    assign reg_wr_start = !wr_cpu_n && wr_prev_q && reg_hit;
    assign busy         = (state_q != IDLE);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            src_q     <= 8'h00;
            idx_q     <= 8'h00;
            data_q    <= 8'h00;
            wr_prev_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
            wr_prev_q <= wr_cpu_n;
        end
    end

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        idx_d   = idx_q;
        data_d  = data_q;
        if (reg_wr_start) begin
            src_d   = Do_cpu;
            idx_d   = 8'h00;
            state_d = SETUP;
        end else if (!cpu_owns) begin
            case (state_q)
                SETUP: state_d = READ;
                READ: begin
                    data_d  = Di;
                    state_d = WRITE;
                end
                WRITE: begin
                    idx_d   = idx_q + 8'd1;
                    state_d = (idx_q == LAST_IDX) ? IDLE : READ;
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        A      = A_cpu;
        Do     = Do_cpu;
        rd_n   = 1'b1;
        wr_n   = 1'b1;
        Di_cpu = Di;
        if (reg_hit) begin
            Di_cpu = src_q;
        end else if (state_q == IDLE || cpu_owns) begin
            rd_n = rd_cpu_n;
            wr_n = wr_cpu_n;
        end else begin
            // Blocked CPU reads see an open bus; blocked writes simply vanish.
            Di_cpu = 8'hFF;
            if (state_q == READ) begin
                A    = {map_src(src_q), idx_q};
                rd_n = 1'b0;
            end else if (state_q == WRITE) begin
                A    = OAM_BASE + {8'h00, idx_q};
                Do   = data_q;
                wr_n = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_oam_dma_controller.sv
// Bench for oam_dma_controller: memory model, OAM-write scoreboard, idle vector table, DMA corner sequences.
module tb_oam_dma_controller;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [15:0] A_cpu;
    logic [7:0]  Do_cpu;
    logic [7:0]  Di_cpu;
    logic        rd_cpu_n;
    logic        wr_cpu_n;
    logic [15:0] A;
    logic [7:0]  Do;
    logic [7:0]  Di;
    logic        rd_n;
    logic        wr_n;
    logic        busy;

    oam_dma_controller dut (
        .clock   (clock),
        .reset_n (reset_n),
        .A_cpu   (A_cpu),
        .Do_cpu  (Do_cpu),
        .Di_cpu  (Di_cpu),
        .rd_cpu_n(rd_cpu_n),
        .wr_cpu_n(wr_cpu_n),
        .A       (A),
        .Do      (Do),
        .Di      (Di),
        .rd_n    (rd_n),
        .wr_n    (wr_n),
        .busy    (busy)
    );

    always #5 clock = ~clock;

    logic [7:0] mem [0:65535];
    assign Di = mem[A];
    always @(posedge clock) if (!wr_n) mem[A] <= Do;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct packed {
        logic [15:0] a;
        logic [7:0]  d;
    } oam_t;
    oam_t q[$];

    int oam_total = 0;
    int first_cyc = 0;
    int last_cyc  = 0;

    always @(negedge clock) begin
        if (reset_n && !wr_n && A[15:8] == 8'hFE) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL oam_unexpected: got write %0h=%0h expected none", A, Do);
            end else begin
                oam_t e;
                e = q.pop_front();
                chk("oam_addr", A, e.a);
                chk("oam_data", Do, e.d);
                if (q.size() == 159) first_cyc = cyc;
            end
            oam_total++;
            last_cyc = cyc;
        end
    end

    int t_wr;
    int start_total;

    // Called #1 after a posedge; returns after the first READ cycle has been checked.
    task automatic start_dma(input logic [7:0] v);
        logic [7:0] base;
        base = (v >= 8'hE0) ? v - 8'h20 : v;
        A_cpu = 16'hFF46; Do_cpu = v; wr_cpu_n = 1'b0; rd_cpu_n = 1'b1;
        q.delete();
        for (int i = 0; i < 160; i++) begin
            oam_t e;
            e.a = 16'hFE00 + 16'(i);
            e.d = mem[{base, 8'(i)}];
            q.push_back(e);
        end
        start_total = oam_total;
        @(posedge clock); #1;
        t_wr = cyc - 1;
        A_cpu = 16'h0000; wr_cpu_n = 1'b1;
        @(negedge clock);
        chk("setup_busy", busy, 1'b1);
        chk("setup_rd_n", rd_n, 1'b1);
        chk("setup_wr_n", wr_n, 1'b1);
        @(posedge clock); #1;
        @(negedge clock);
        chk("first_read_addr", A, {base, 8'h00});
        chk("first_read_rd_n", rd_n, 1'b0);
    endtask

    task automatic wait_writes(input int n);
        int k;
        k = 0;
        while (oam_total - start_total < n && k < 2000) begin
            @(posedge clock);
            k++;
        end
        if (k >= 2000) begin
            checks++; errors++;
            $display("FAIL wait_writes: got %0d writes expected %0d", oam_total - start_total, n);
        end
    endtask

    task automatic wait_idle(input int exp_cyc);
        int k;
        k = 0;
        @(negedge clock);
        while (busy && k < 1000) begin
            @(negedge clock);
            k++;
        end
        chk("busy_fall_cycle", cyc, exp_cyc);
        chk("last_write_cycle", last_cyc, exp_cyc - 1);
        chk("scoreboard_empty", q.size(), 0);
        @(posedge clock); #1;
    endtask

    typedef struct {
        string       name;
        logic [15:0] a;
        logic [7:0]  d;
        logic        rd;
        logic        wr;
        logic [15:0] exp_a;
        logic        exp_rd;
        logic        exp_wr;
        logic        chk_di;
        logic [7:0]  exp_di;
    } vec_t;
    vec_t vecs[6];

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'(i) ^ 8'(i >> 8);
        for (int i = 0; i < 160; i++) begin
            mem[16'hC100 + i] = 8'(i) ^ 8'h5A;
            mem[16'hD000 + i] = 8'(i * 3 + 1);
            mem[16'hDE00 + i] = ~8'(i);
        end
        mem[16'h0150] = 8'h3C;
        mem[16'hC000] = 8'h00;
        mem[16'hFF85] = 8'hA5;

        vecs[0] = '{"idle_quiet",  16'h1234, 8'h00, 1'b1, 1'b1, 16'h1234, 1'b1, 1'b1, 1'b0, 8'h00};
        vecs[1] = '{"idle_rd",     16'h0150, 8'h00, 1'b0, 1'b1, 16'h0150, 1'b0, 1'b1, 1'b1, 8'h3C};
        vecs[2] = '{"idle_wr",     16'hC000, 8'h77, 1'b1, 1'b0, 16'hC000, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[3] = '{"reg_rd",      16'hFF46, 8'h00, 1'b0, 1'b1, 16'hFF46, 1'b1, 1'b1, 1'b1, 8'h00};
        vecs[4] = '{"idle_hram",   16'hFF85, 8'h00, 1'b0, 1'b1, 16'hFF85, 1'b0, 1'b1, 1'b1, 8'hA5};
        vecs[5] = '{"idle_rdback", 16'hC000, 8'h00, 1'b0, 1'b1, 16'hC000, 1'b0, 1'b1, 1'b1, 8'h77};

        reset_n = 1'b0; A_cpu = 16'h0000; Do_cpu = 8'h00; rd_cpu_n = 1'b1; wr_cpu_n = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        @(negedge clock);
        chk("reset_busy", busy, 1'b0);
        chk("reset_rd_n", rd_n, 1'b1);
        chk("reset_wr_n", wr_n, 1'b1);
        @(posedge clock); #1;
        reset_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            A_cpu = vecs[i].a; Do_cpu = vecs[i].d; rd_cpu_n = vecs[i].rd; wr_cpu_n = vecs[i].wr;
            @(negedge clock);
            chk({vecs[i].name, "_A"}, A, vecs[i].exp_a);
            chk({vecs[i].name, "_Do"}, Do, vecs[i].d);
            chk({vecs[i].name, "_rd_n"}, rd_n, vecs[i].exp_rd);
            chk({vecs[i].name, "_wr_n"}, wr_n, vecs[i].exp_wr);
            chk({vecs[i].name, "_busy"}, busy, 1'b0);
            if (vecs[i].chk_di) chk({vecs[i].name, "_Di_cpu"}, Di_cpu, vecs[i].exp_di);
            @(posedge clock); #1;
        end
        rd_cpu_n = 1'b1; wr_cpu_n = 1'b1; A_cpu = 16'h0000;

        // Plain transfer from C100
        start_dma(8'hC1);
        wait_idle(t_wr + 322);
        chk("first_write_cycle", first_cyc, t_wr + 3);

        // Blocked CPU traffic mid-transfer
        start_dma(8'hC1);
        repeat (10) @(posedge clock);
        #1;
        A_cpu = 16'h0150; rd_cpu_n = 1'b0;
        @(negedge clock);
        chk("blocked_rd_Di_cpu", Di_cpu, 8'hFF);
        chk("blocked_rd_not_fwd", A != 16'h0150, 1'b1);
        @(posedge clock); #1;
        rd_cpu_n = 1'b1; A_cpu = 16'hC000; Do_cpu = 8'h99; wr_cpu_n = 1'b0;
        @(negedge clock);
        chk("blocked_wr_not_fwd", A != 16'hC000, 1'b1);
        @(posedge clock); #1;
        wr_cpu_n = 1'b1; A_cpu = 16'h0000;
        wait_idle(t_wr + 322);
        chk("blocked_wr_mem", mem[16'hC000], 8'h77);

        // HRAM stall at idx 40
        start_dma(8'hC1);
        wait_writes(40);
        #1;
        A_cpu = 16'hFF85; rd_cpu_n = 1'b0;
        @(negedge clock);
        chk("hram_A", A, 16'hFF85);
        chk("hram_rd_n", rd_n, 1'b0);
        chk("hram_Di_cpu", Di_cpu, 8'hA5);
        chk("hram_busy", busy, 1'b1);
        @(posedge clock); #1;
        rd_cpu_n = 1'b1; A_cpu = 16'h0000;
        @(negedge clock);
        chk("hram_resume_A", A, 16'hC128);
        wait_idle(t_wr + 323);

        // Restart with D0 at idx 50
        start_dma(8'hC1);
        wait_writes(50);
        #1;
        start_dma(8'hD0);
        wait_idle(t_wr + 322);

        // Echo-RAM source
        start_dma(8'hFE);
        wait_idle(t_wr + 322);
        A_cpu = 16'hFF46; rd_cpu_n = 1'b0;
        @(negedge clock);
        chk("reg_readback_FE", Di_cpu, 8'hFE);
        @(posedge clock); #1;
        rd_cpu_n = 1'b1; A_cpu = 16'h0000;

        // Reset mid-transfer at idx 80
        start_dma(8'hC1);
        wait_writes(80);
        #1;
        reset_n = 1'b0;
        q.delete();
        @(posedge clock); #1;
        reset_n = 1'b1; A_cpu = 16'hFF46; rd_cpu_n = 1'b0;
        @(negedge clock);
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_rd_n", rd_n, 1'b1);
        chk("rst_mid_wr_n", wr_n, 1'b1);
        chk("rst_mid_src", Di_cpu, 8'h00);
        @(posedge clock); #1;
        A_cpu = 16'h0150;
        @(negedge clock);
        chk("rst_pass_A", A, 16'h0150);
        chk("rst_pass_rd_n", rd_n, 1'b0);
        chk("rst_pass_Di_cpu", Di_cpu, 8'h3C);
        @(posedge clock); #1;
        rd_cpu_n = 1'b1; A_cpu = 16'h0000;
        repeat (4) @(posedge clock);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
